fetch_stage: RTL and testbench

Instruction fetch stage directly downstream of the program counter. Takes the PC value each cycle, reads a synchronous-read instruction memory, and presents the fetched instruction with its address to decode through a valid/ready handshake. It back-pressures the PC with a stall, squashes wrong-path fetches on flush, and drains and parks cleanly when the PC raises halt. The instruction memory is loaded through a program port after reset, before execution starts.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/instr_rom.sv | 42 ++++
 rtl/fetch_stage.sv | 119 +++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned IW_DEFAULT    = 9;
  localparam int unsigned AW_DEFAULT    = 10;
  localparam int unsigned DEPTH_DEFAULT = 1024;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [IW_DEFAULT-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/instr_rom.sv
// Single-port instruction memory: synchronous write, synchronous read with
// read enable. Out-of-range addresses read as NOP and drop writes.
module instr_rom
  import fetch_pkg::*;
#(
  parameter int unsigned IW    = IW_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [IW-1:0] wdata,
  output logic [IW-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0]    mem [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             in_range;

  assign in_range = (32'(addr) < DEPTH);
  assign idx      = IDX_W'(addr);

  // Array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we && in_range) mem[idx] <= wdata;
  end

  // Read register; holds its value whenever the read is not enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= in_range ? mem[idx] : IW'(NOP_INSTR);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: program load, fetch with valid/ready hand-off to
// decode, PC back-pressure, flush squash and halt drain.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned IW    = IW_DEFAULT,
  parameter int unsigned AW    = AW_DEFAULT,
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic          CLK,
  input  logic          init_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [IW-1:0] prog_data,
  input  logic          prog_done,
  input  logic [AW-1:0] pc,
  input  logic          pc_halt,
  input  logic          flush,
  input  logic          dec_ready,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  output logic          stall,
  output logic          halted,
  output logic [AW:0]   load_count
);

  localparam logic [AW:0] LOAD_MAX = {1'b1, {AW{1'b0}}};

  fetch_state_t  state, state_d;
  logic          valid_d;
  logic          halted_d;
  logic          rom_we;
  logic          rom_re;
  logic          count_en;
  logic [AW-1:0] rom_addr;

  // Memory port is shared: program address while loading, PC otherwise.
  instr_rom #(
    .IW    (IW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_rom (
    .clk   (CLK),
    .rst_n (init_n),
    .we    (rom_we),
    .re    (rom_re),
    .addr  (rom_addr),
    .wdata (prog_data),
    .rdata (instr)
  );

  // State register.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) state <= LOAD;
    else         state <= state_d;
  end

  // Next state, stall, memory control and next valid/halted.
  always_comb begin
    state_d  = state;
    valid_d  = instr_valid;
    halted_d = halted;
    stall    = 1'b1;
    rom_we   = 1'b0;
    rom_re   = 1'b0;
    rom_addr = pc;
    count_en = 1'b0;
    case (state)
      LOAD: begin
        rom_addr = prog_addr;
        rom_we   = prog_we;
        count_en = prog_we && (load_count != LOAD_MAX);
        if (prog_done) state_d = RUN;
      end
      RUN: begin
        stall = instr_valid & ~dec_ready;
        if (flush) begin
          valid_d = 1'b0;
        end else if (pc_halt) begin
          // No new fetch; a word still waiting on decode is kept for DRAIN.
          state_d = DRAIN;
          if (!stall) valid_d = 1'b0;
        end else if (!stall) begin
          rom_re  = 1'b1;
          valid_d = 1'b1;
        end
      end
      DRAIN: begin
        if (!instr_valid || dec_ready) begin
          valid_d  = 1'b0;
          halted_d = 1'b1;
          state_d  = HALTED;
        end
      end
      HALTED: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

  // Output and bookkeeping registers.
  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      load_count  <= '0;
    end else begin
      instr_valid <= valid_d;
      halted      <= halted_d;
      if (rom_re)   instr_pc   <= pc;
      if (count_en) load_count <= load_count + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table plus hand-written sequences.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        init_n;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [8:0]  prog_data;
  logic        prog_done;
  logic [9:0]  pc;
  logic        pc_halt;
  logic        flush;
  logic        dec_ready;

  logic [8:0]  instr;
  logic [9:0]  instr_pc;
  logic        instr_valid, stall, halted;
  logic [10:0] load_count;

  logic [8:0]  d8_instr;
  logic [9:0]  d8_instr_pc;
  logic        d8_valid, d8_stall, d8_halted;
  logic [10:0] d8_load_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  fetch_stage #(.IW(9), .AW(10), .DEPTH(1024)) dut (
    .CLK(CLK), .init_n(init_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_done(prog_done), .pc(pc), .pc_halt(pc_halt),
    .flush(flush), .dec_ready(dec_ready), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .stall(stall), .halted(halted),
    .load_count(load_count)
  );

  fetch_stage #(.IW(9), .AW(10), .DEPTH(8)) dut8 (
    .CLK(CLK), .init_n(init_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_done(prog_done), .pc(pc), .pc_halt(pc_halt),
    .flush(flush), .dec_ready(dec_ready), .instr(d8_instr),
    .instr_pc(d8_instr_pc), .instr_valid(d8_valid), .stall(d8_stall),
    .halted(d8_halted), .load_count(d8_load_count)
  );

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [8:0]  data;
    logic        done;
    logic [9:0]  p;
    logic        halt;
    logic        fl;
    logic        rdy;
    logic        e_stall;
    logic [8:0]  e_instr;
    logic [9:0]  e_pc;
    logic        e_valid;
    logic        e_halted;
    logic [10:0] e_lc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(logic we, logic [9:0] a, logic [8:0] d, logic done,
                              logic [9:0] p, logic h, logic f, logic r,
                              logic es, logic [8:0] ei, logic [9:0] ep,
                              logic ev, logic eh, logic [10:0] el);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.done = done; v.p = p; v.halt = h;
    v.fl = f; v.rdy = r; v.e_stall = es; v.e_instr = ei; v.e_pc = ep;
    v.e_valid = ev; v.e_halted = eh; v.e_lc = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one vector for a cycle: stall is checked mid-cycle, registers after the edge.
  task automatic apply(input int idx, input vec_t v);
    logic st;
    prog_we = v.we; prog_addr = v.addr; prog_data = v.data; prog_done = v.done;
    pc = v.p; pc_halt = v.halt; flush = v.fl; dec_ready = v.rdy;
    #4;
    st = stall;
    @(posedge CLK);
    #1;
    check($sformatf("vec%0d", idx),
          64'({st, instr, instr_pc, instr_valid, halted, load_count}),
          64'({v.e_stall, v.e_instr, v.e_pc, v.e_valid, v.e_halted, v.e_lc}));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //             we addr   data    dn pc     h  f  r | st instr  ipc    v  h  lc
    vecs[0]  = mk(1, 10'd0, 9'h011, 0, 10'd0, 0, 0, 0,  1, 9'h000, 10'd0, 0, 0, 11'd1);
    vecs[1]  = mk(1, 10'd1, 9'h022, 0, 10'd0, 0, 0, 0,  1, 9'h000, 10'd0, 0, 0, 11'd2);
    vecs[2]  = mk(1, 10'd2, 9'h033, 0, 10'd0, 0, 0, 0,  1, 9'h000, 10'd0, 0, 0, 11'd3);
    vecs[3]  = mk(1, 10'd3, 9'h044, 1, 10'd0, 0, 0, 0,  1, 9'h000, 10'd0, 0, 0, 11'd4);
    vecs[4]  = mk(0, 10'd0, 9'h000, 0, 10'd0, 0, 0, 1,  0, 9'h011, 10'd0, 1, 0, 11'd4);
    vecs[5]  = mk(0, 10'd0, 9'h000, 0, 10'd1, 0, 0, 1,  0, 9'h022, 10'd1, 1, 0, 11'd4);
    vecs[6]  = mk(0, 10'd0, 9'h000, 0, 10'd2, 0, 0, 0,  1, 9'h022, 10'd1, 1, 0, 11'd4);
    vecs[7]  = mk(0, 10'd0, 9'h000, 0, 10'd2, 0, 0, 0,  1, 9'h022, 10'd1, 1, 0, 11'd4);
    vecs[8]  = mk(0, 10'd0, 9'h000, 0, 10'd2, 0, 0, 0,  1, 9'h022, 10'd1, 1, 0, 11'd4);
    vecs[9]  = mk(0, 10'd0, 9'h000, 0, 10'd2, 0, 0, 1,  0, 9'h033, 10'd2, 1, 0, 11'd4);
    vecs[10] = mk(0, 10'd0, 9'h000, 0, 10'd3, 0, 0, 1,  0, 9'h044, 10'd3, 1, 0, 11'd4);
    vecs[11] = mk(0, 10'd0, 9'h000, 0, 10'd2, 0, 1, 1,  0, 9'h044, 10'd3, 0, 0, 11'd4);
    vecs[12] = mk(0, 10'd0, 9'h000, 0, 10'd3, 0, 0, 1,  0, 9'h044, 10'd3, 1, 0, 11'd4);
    vecs[13] = mk(0, 10'd0, 9'h000, 0, 10'd0, 0, 1, 0,  1, 9'h044, 10'd3, 0, 0, 11'd4);
    vecs[14] = mk(1, 10'd0, 9'h1FF, 0, 10'd0, 0, 0, 1,  0, 9'h011, 10'd0, 1, 0, 11'd4);
    vecs[15] = mk(0, 10'd0, 9'h000, 0, 10'd1, 0, 0, 1,  0, 9'h022, 10'd1, 1, 0, 11'd4);
    vecs[16] = mk(0, 10'd0, 9'h000, 0, 10'd2, 1, 0, 0,  1, 9'h022, 10'd1, 1, 0, 11'd4);
    vecs[17] = mk(0, 10'd0, 9'h000, 0, 10'd2, 1, 0, 0,  1, 9'h022, 10'd1, 1, 0, 11'd4);
    vecs[18] = mk(0, 10'd0, 9'h000, 0, 10'd2, 1, 0, 1,  1, 9'h022, 10'd1, 0, 1, 11'd4);
    vecs[19] = mk(1, 10'd5, 9'h155, 1, 10'd2, 1, 0, 1,  1, 9'h022, 10'd1, 0, 1, 11'd4);
    vecs[20] = mk(0, 10'd0, 9'h000, 0, 10'd0, 0, 0, 1,  1, 9'h022, 10'd1, 0, 1, 11'd4);

    init_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_done = 1'b0;
    pc = '0; pc_halt = 1'b0; flush = 1'b0; dec_ready = 1'b0;
    #12;
    check("reset", 64'({stall, instr, instr_pc, instr_valid, halted, load_count}),
          64'({1'b1, 9'h000, 10'd0, 1'b0, 1'b0, 11'd0}));
    @(posedge CLK);
    #1;
    init_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(i, vecs[i]);

    // Reset out of HALTED, asynchronously mid-cycle.
    #3 init_n = 1'b0;
    #1;
    check("rst_halted", 64'({stall, instr_valid, halted, load_count}),
          64'({1'b1, 1'b0, 1'b0, 11'd0}));

    // Restart without reloading: memory must hold the LOAD contents, not the RUN write.
    @(posedge CLK);
    #1;
    init_n = 1'b1; prog_we = 1'b0; pc_halt = 1'b0; flush = 1'b0; dec_ready = 1'b0;
    prog_done = 1'b1;
    tick();
    prog_done = 1'b0; pc = 10'd0; dec_ready = 1'b1;
    tick();
    check("mem_kept", 64'({instr, instr_pc, instr_valid, halted, load_count}),
          64'({9'h011, 10'd0, 1'b1, 1'b0, 11'd0}));

    // Small memory: in-range word, then an address past the end reads as zero.
    pc = 10'd3;
    tick();
    check("d8_in", 64'({d8_instr, d8_instr_pc, d8_valid}), 64'({9'h044, 10'd3, 1'b1}));
    pc = 10'd9;
    tick();
    check("d8_oob", 64'({d8_instr, d8_instr_pc, d8_valid, d8_halted, d8_stall, d8_load_count}),
          64'({9'h000, 10'd9, 1'b1, 1'b0, 1'b0, 11'd0}));

    // Reset mid-RUN with a valid word in flight.
    #3 init_n = 1'b0;
    #1;
    check("rst_run", 64'({stall, instr, instr_pc, instr_valid, halted, load_count}),
          64'({1'b1, 9'h000, 10'd0, 1'b0, 1'b0, 11'd0}));

    // load_count saturates at 2^AW.
    @(posedge CLK);
    #1;
    init_n = 1'b1; prog_we = 1'b1; dec_ready = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      prog_addr = 10'(i);
      prog_data = 9'(i);
      tick();
    end
    prog_we = 1'b0;
    check("lc_sat", 64'(load_count), 64'(11'h400));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
